modexp_ctrl: RTL and testbench
==============================

MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 1024: operand/modulus width.
REQ-002 SHALL have parameter EXP_W, default 1024: exponent width.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a modular exponentiation; sampled only in IDLE.
REQ-007 in_x  input  DATA_W  base, normal domain, must be < in_m.
REQ-008 in_e  input  EXP_W  exponent.
REQ-009 in_m  input  DATA_W  odd modulus.
REQ-010 in_rmodm  input  DATA_W  R mod M, with R = 2^DATA_W.
REQ-011 in_r2modm  input  DATA_W  R^2 mod M.
REQ-012 busy  output  1  high from the cycle after start acceptance until done.
REQ-013 done  output  1  one-cycle pulse when result is valid.
REQ-014 result  output  DATA_W  x^e mod M; held until the next accepted start.
REQ-015 mm_start  output  1  one-cycle pulse launching one Montgomery multiply.
REQ-016 mm_a, mm_b  output  DATA_W each  multiplier operands; stable from mm_start until mm_done.
REQ-017 mm_m  output  DATA_W  modulus to the multiplier, equal to latched M.
REQ-018 mm_result  input  DATA_W+1  multiplier output; only bits [DATA_W-1:0] are used.
REQ-019 mm_done  input  1  one-cycle pulse; mm_result is valid in that cycle.

Function
REQ-020 On start in IDLE, SHALL latch in_x, in_e, in_m, in_rmodm and in_r2modm; later input changes SHALL have no effect.
REQ-021 The FSM SHALL use states IDLE, TOMONT, SQUARE, MULT, FROMMONT, FIN.
- IDLE -> TOMONT on start.
- TOMONT: xm = MM(x, R2).
- SQUARE: A = MM(A, A), with A initialised to R mod M.
- MULT: A = MM(A, xm), entered only when the current exponent bit is 1.
- FROMMONT: A = MM(A, 1).
- FIN: done pulse -> IDLE.
REQ-022 Exponent bits SHALL be processed MSB first, index EXP_W-1 down to 0, by a down-counter.
- After SQUARE: go to MULT if the bit is 1, else advance.
- After the bit-0 step: go to FROMMONT.
REQ-023 Each state SHALL issue exactly one mm_start and wait for mm_done.
- mm_start is asserted the cycle after state entry.
- mm_done outside a wait SHALL be ignored.
REQ-024 Latency: start sampled at edge k -> first mm_start high in cycle k+1; mm_done at edge j -> next mm_start in cycle j+1; final mm_done at edge j -> done high in cycle j+1.
REQ-025 start while busy SHALL be ignored; start in the done cycle SHALL be ignored.
REQ-026 e = 0 SHALL yield result = 1 (assuming M > 1).
REQ-027 mm_start, done and busy SHALL never be high simultaneously with a reset assertion.

Reset
REQ-028 resetn low SHALL immediately force state IDLE and all outputs and registers to zero.
REQ-029 Reset mid-operation SHALL abandon the computation with no done pulse; the multiplier shares resetn.

Configuration
REQ-030 Macro MODEXP_SKIP_LEADING_ZEROS_EN SHALL control leading-zero skipping of the exponent.
- Defined: after TOMONT, SHALL skip zero MSBs at one bit per cycle without multiplies; e = 0 goes straight to FROMMONT.
- Undefined: all EXP_W bits SHALL be squared.
- The result SHALL be identical in both cases; only the mm_start count and latency differ.

Verification
REQ-031 The bench SHALL use DATA_W=16, EXP_W=8, M=0x00F1, R mod M=0x00E1, R2 mod M=0x000F, and a behavioural MM model with fixed 5-cycle mm_done latency.
REQ-032 x=3, e=0x05 -> result 0x0002; mm_start count 12 without macro, 7 with macro.
REQ-033 x=2, e=0xFF -> result 0x00E9; mm_start count 18 in both builds.
REQ-034 x=7, e=0x00 -> result 0x0001; mm_start count 10 without macro, 2 with macro.
REQ-035 start pulsed again mid-run with different operands -> ignored; first result 0x0002 delivered; single done pulse.
REQ-036 resetn dropped during the third multiply -> busy=0, mm_start=0, no done; subsequent start computes correctly.

Source files
------------

// File: rtl/modexp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : modexp_ctrl_if
// Brief   : Host request/response and Montgomery-multiplier handshake bundle
//           for modexp_ctrl.
// Revision: 1.0
// ============================================================================
interface modexp_ctrl_if #(
    parameter int DATA_W = 1024,
    parameter int EXP_W  = 1024
);
    logic              start;
    logic [DATA_W-1:0] in_x;
    logic [EXP_W-1:0]  in_e;
    logic [DATA_W-1:0] in_m;
    logic [DATA_W-1:0] in_rmodm;
    logic [DATA_W-1:0] in_r2modm;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              mm_start;
    logic [DATA_W-1:0] mm_a;
    logic [DATA_W-1:0] mm_b;
    logic [DATA_W-1:0] mm_m;
    logic [DATA_W:0]   mm_result;
    logic              mm_done;

    // The controller side.
    modport slave (
        input  start, in_x, in_e, in_m, in_rmodm, in_r2modm, mm_result, mm_done,
        output busy, done, result, mm_start, mm_a, mm_b, mm_m
    );

    // The host plus multiplier side.
    modport master (
        output start, in_x, in_e, in_m, in_rmodm, in_r2modm, mm_result, mm_done,
        input  busy, done, result, mm_start, mm_a, mm_b, mm_m
    );
endinterface
`default_nettype wire

// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : modexp_ctrl
// Brief   : Left-to-right square-and-multiply modular exponentiation sequencer
//           driving an external Montgomery multiplier.
//           Optional macro MODEXP_SKIP_LEADING_ZEROS_EN skips leading zero
//           exponent bits without issuing multiplies.
// Revision: 1.0
// ============================================================================
module modexp_ctrl #(
    parameter int DATA_W = 1024,
    parameter int EXP_W  = 1024
) (
    input  wire          clk,
    input  wire          resetn,
    modexp_ctrl_if.slave bus
);
    localparam int                IDX_W   = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0]  C_MSB   = IDX_W'(EXP_W - 1);
    localparam logic [DATA_W-1:0] C_ONE   = DATA_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TOMONT   = 3'd1,
        S_SQUARE   = 3'd2,
        S_MULT     = 3'd3,
        S_FROMMONT = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic              r_mm_start;
    logic [DATA_W-1:0] r_mm_a;
    logic [DATA_W-1:0] r_mm_b;
    logic [DATA_W-1:0] r_mm_m;
    logic [EXP_W-1:0]  r_e;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_xm;
    logic [IDX_W-1:0]  r_idx;
    logic              r_wait;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    logic              r_skip;
`endif

    logic              w_mm_ack;
    logic [DATA_W-1:0] w_res;
    logic              w_bit;
    logic              w_last;
    state_t            w_adv_state;
    logic [DATA_W-1:0] w_adv_b;
    logic [IDX_W-1:0]  w_adv_idx;
    logic              w_unused_msb;

    assign w_mm_ack     = r_wait & bus.mm_done;
    assign w_res        = bus.mm_result[DATA_W-1:0];
    assign w_unused_msb = bus.mm_result[DATA_W];
    assign w_bit        = r_e[r_idx];
    assign w_last       = (r_idx == '0);

    // Moving past the current bit: next square, or leave the Montgomery domain.
    always_comb begin
        w_adv_state = S_SQUARE;
        w_adv_b     = w_res;
        w_adv_idx   = r_idx - 1'b1;
        if (w_last) begin
            w_adv_state = S_FROMMONT;
            w_adv_b     = C_ONE;
            w_adv_idx   = r_idx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_mm_start <= 1'b0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_mm_m     <= '0;
            r_e        <= '0;
            r_acc      <= '0;
            r_xm       <= '0;
            r_idx      <= '0;
            r_wait     <= 1'b0;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            r_skip     <= 1'b0;
`endif
        end else begin
            r_mm_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_TOMONT;
                        r_busy     <= 1'b1;
                        r_wait     <= 1'b1;
                        r_mm_start <= 1'b1;
                        r_mm_a     <= bus.in_x;
                        r_mm_b     <= bus.in_r2modm;
                        r_mm_m     <= bus.in_m;
                        r_e        <= bus.in_e;
                        r_acc      <= bus.in_rmodm;
                        r_idx      <= C_MSB;
                    end
                end
                S_TOMONT: begin
                    if (w_mm_ack) begin
                        r_xm    <= w_res;
                        r_state <= S_SQUARE;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                        r_wait  <= 1'b0;
                        r_skip  <= 1'b1;
`else
                        r_mm_start <= 1'b1;
                        r_mm_a     <= r_acc;
                        r_mm_b     <= r_acc;
`endif
                    end
                end
                S_SQUARE: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                    // Accumulator is still Montgomery-one, so zero MSBs cost one idle cycle each.
                    if (r_skip) begin
                        if (w_bit) begin
                            r_skip     <= 1'b0;
                            r_wait     <= 1'b1;
                            r_mm_start <= 1'b1;
                            r_mm_a     <= r_acc;
                            r_mm_b     <= r_acc;
                        end else if (w_last) begin
                            r_skip     <= 1'b0;
                            r_wait     <= 1'b1;
                            r_mm_start <= 1'b1;
                            r_state    <= S_FROMMONT;
                            r_mm_a     <= r_acc;
                            r_mm_b     <= C_ONE;
                        end else begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end else
`endif
                    if (w_mm_ack) begin
                        r_mm_start <= 1'b1;
                        r_mm_a     <= w_res;
                        if (w_bit) begin
                            r_state <= S_MULT;
                            r_mm_b  <= r_xm;
                        end else begin
                            r_state <= w_adv_state;
                            r_mm_b  <= w_adv_b;
                            r_idx   <= w_adv_idx;
                        end
                    end
                end
                S_MULT: begin
                    if (w_mm_ack) begin
                        r_mm_start <= 1'b1;
                        r_mm_a     <= w_res;
                        r_state    <= w_adv_state;
                        r_mm_b     <= w_adv_b;
                        r_idx      <= w_adv_idx;
                    end
                end
                S_FROMMONT: begin
                    if (w_mm_ack) begin
                        r_wait   <= 1'b0;
                        r_result <= w_res;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_wait  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.mm_start = r_mm_start;
    assign bus.mm_a     = r_mm_a;
    assign bus.mm_b     = r_mm_b;
    assign bus.mm_m     = r_mm_m;
endmodule
`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_modexp_ctrl
// Brief   : Self-checking bench for modexp_ctrl with a 5-cycle Montgomery
//           multiplier model and an integer modexp reference.
// Revision: 1.0
// ============================================================================
module tb_modexp_ctrl;
    localparam int     DW = 16;
    localparam int     EW = 8;
    localparam longint M  = 64'h00F1;
    localparam longint RM = 64'h00E1;
    localparam longint R2 = 64'h000F;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_mmstart = 0;
    int   n_done = 0;
    int   mm_cnt = 0;
    bit   mm_pend = 1'b0;
    longint mm_opa = 0;
    longint mm_opb = 0;

    modexp_ctrl_if #(.DATA_W(DW), .EXP_W(EW)) bus ();

    modexp_ctrl #(.DATA_W(DW), .EXP_W(EW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic longint mm_ref(input longint a, input longint b);
        longint t;
        t = a * b;
        for (int i = 0; i < DW; i++) begin
            if ((t & 1) != 0) t = t + M;
            t = t >> 1;
        end
        if (t >= M) t = t - M;
        return t;
    endfunction

    function automatic longint ref_pow(input longint x, input int e);
        longint r;
        longint b;
        r = 1 % M;
        b = x % M;
        for (int i = 0; i < EW; i++) begin
            if (((e >> i) & 1) != 0) r = (r * b) % M;
            b = (b * b) % M;
        end
        return r;
    endfunction

    function automatic int ref_cnt(input int e);
        int nsq;
        int pop;
        nsq = EW;
        pop = 0;
        for (int i = 0; i < EW; i++) if (((e >> i) & 1) != 0) pop++;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        nsq = 0;
        for (int i = 0; i < EW; i++) if (((e >> i) & 1) != 0) nsq = i + 1;
`endif
        return 2 + nsq + pop;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Multiplier model: fixed latency, shares the controller reset.
    initial begin
        bus.mm_done   = 1'b0;
        bus.mm_result = '0;
        forever begin
            @(negedge clk);
            bus.mm_done = 1'b0;
            if (!resetn) begin
                mm_pend = 1'b0;
                mm_cnt  = 0;
            end else begin
                if (mm_pend) begin
                    mm_cnt--;
                    if (mm_cnt == 0) begin
                        bus.mm_done   = 1'b1;
                        bus.mm_result = (DW+1)'(mm_ref(mm_opa, mm_opb));
                        mm_pend       = 1'b0;
                    end
                end
                if (bus.mm_start === 1'b1) begin
                    n_mmstart++;
                    mm_pend = 1'b1;
                    mm_cnt  = 5;
                    mm_opa  = longint'(bus.mm_a);
                    mm_opb  = longint'(bus.mm_b);
                    chk("mm_m", 32'(bus.mm_m), 32'(M));
                end
            end
            if (bus.done === 1'b1) n_done++;
        end
    end

    task automatic drive_ops(input logic [DW-1:0] x, input logic [EW-1:0] e);
        bus.in_x      = x;
        bus.in_e      = e;
        bus.in_m      = DW'(M);
        bus.in_rmodm  = DW'(RM);
        bus.in_r2modm = DW'(R2);
    endtask

    task automatic run_op(input logic [DW-1:0] x, input logic [EW-1:0] e,
                          input bit mid, input string tag);
        longint exp_res;
        int     exp_cnt;
        int     cyc;
        bit     got;
        exp_res   = ref_pow(longint'(x), int'(e));
        exp_cnt   = ref_cnt(int'(e));
        n_mmstart = 0;
        n_done    = 0;
        drive_ops(x, e);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        // Scramble inputs; they were latched at acceptance.
        bus.in_x      = DW'($urandom);
        bus.in_e      = EW'($urandom);
        bus.in_m      = DW'($urandom);
        bus.in_rmodm  = DW'($urandom);
        bus.in_r2modm = DW'($urandom);
        if (mid) begin
            repeat (15) @(posedge clk);
            #1;
            drive_ops(DW'(7), EW'(8'hFF));
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_result"}, 32'(bus.result), 32'(exp_res));
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        drive_ops(DW'(5), EW'(8'h03));
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_start_in_done_ignored"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk({tag, "_result_held"}, 32'(bus.result), 32'(exp_res));
        chk({tag, "_done_count"}, 32'(n_done), 32'd1);
        chk({tag, "_mm_count"}, 32'(n_mmstart), 32'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.start = 1'b0;
        drive_ops('0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mm_start", 32'(bus.mm_start), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_op(DW'(3), EW'(8'h05), 1'b0, "x3_e05");
        chk("x3_e05_const", 32'(bus.result), 32'h0002);
        run_op(DW'(2), EW'(8'hFF), 1'b0, "x2_eFF");
        chk("x2_eFF_const", 32'(bus.result), 32'h00E9);
        run_op(DW'(7), EW'(8'h00), 1'b0, "x7_e00");
        chk("x7_e00_const", 32'(bus.result), 32'h0001);
        run_op(DW'(3), EW'(8'h05), 1'b1, "midstart");
        chk("midstart_const", 32'(bus.result), 32'h0002);

        for (int i = 0; i < 6; i++) begin
            run_op(DW'($urandom_range(0, 240)), EW'($urandom_range(0, 255)), 1'b0, "rand");
        end

        // Abort during the third multiply.
        n_mmstart = 0;
        n_done    = 0;
        drive_ops(DW'(3), EW'(8'h05));
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (n_mmstart < 3 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reach_mm3", 32'(n_mmstart), 32'd3);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_mm_start", 32'(bus.mm_start), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_idle", 32'(bus.busy), 32'd0);
        run_op(DW'(2), EW'(8'hFF), 1'b0, "post_abort");
        chk("post_abort_const", 32'(bus.result), 32'h00E9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
